// File: rtl/led_pkg.sv
// Shared types, seed patterns and mode sequencing helpers for the LED sequencer.
package led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF      = 3'd0,
    MODE_SHL      = 3'd1,
    MODE_SHR      = 3'd2,
    MODE_SPLIT    = 3'd3,
    MODE_BLINK    = 3'd4,
    MODE_OVERRIDE = 3'd5
  } mode_e;

  localparam logic [7:0] SEED_SHL    = 8'hFE;
  localparam logic [7:0] SEED_SHR    = 8'h7F;
  localparam logic [7:0] SEED_SPLIT  = 8'hE7;
  localparam logic [7:0] SEED_BLINK  = 8'h00;
  localparam logic [7:0] LED_ALL_OFF = 8'hFF;

  // Key-driven mode cycle; OVERRIDE is never entered from here.
  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    case (m)
      MODE_OFF:   r = MODE_SHL;
      MODE_SHL:   r = MODE_SHR;
      MODE_SHR:   r = MODE_SPLIT;
      MODE_SPLIT: r = MODE_BLINK;
      default:    r = MODE_OFF;
    endcase
    return r;
  endfunction

  // Pattern loaded on entry to a mode.
  function automatic logic [7:0] mode_seed(input mode_e m);
    logic [7:0] r;
    case (m)
      MODE_SHL:   r = SEED_SHL;
      MODE_SHR:   r = SEED_SHR;
      MODE_SPLIT: r = SEED_SPLIT;
      MODE_BLINK: r = SEED_BLINK;
      default:    r = LED_ALL_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick_gen.sv
// Step timebase: counts 0..P-1 with P = TICK_BASE >> speed_sel and strobes tick on the last count.
module led_tick_gen #(
  parameter int unsigned TICK_BASE = 2_500_000,
  parameter int unsigned CNT_W     = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed_sel,
  input  logic       pause,
  input  logic       restart,
  output logic       tick
);

  localparam logic [CNT_W-1:0] BASE = CNT_W'(TICK_BASE);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;
  logic [1:0]       speed_q;
  logic             speed_chg;

  // Terminal count and speed-change detect; a speed change swallows that cycle's tick.
  always_comb begin
    period_m1 = (BASE >> speed_sel) - CNT_W'(1);
    speed_chg = (speed_sel != speed_q);
    tick      = (cnt == period_m1) && !pause && !speed_chg;
  end

  // Counter: restart and speed change take priority over pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      speed_q <= 2'd0;
    end else begin
      speed_q <= speed_sel;
      if (restart || speed_chg) begin
        cnt <= '0;
      end else if (!pause) begin
        cnt <= (cnt == period_m1) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: mode FSM, pattern register and host override handshake.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned TICK_BASE = 2_500_000,
  parameter int unsigned OVR_TICKS = 10,
  parameter int unsigned CNT_W     = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_req,
  input  logic [1:0] speed_sel,
  input  logic       pause,
  input  logic       ovr_valid,
  input  logic [7:0] ovr_data,
  output logic       ovr_ready,
  output logic [7:0] led_n,
  output logic [2:0] mode,
  output logic       tick
);

  localparam int unsigned HOLD_W = (OVR_TICKS > 1) ? $clog2(OVR_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVR_TICKS - 1);

  mode_e             mode_q, mode_d;
  mode_e             saved_q, saved_d;
  logic [7:0]        led_q, led_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              restart;
  logic              accept;

  // One pattern step for the given mode.
  function automatic logic [7:0] step_pattern(input mode_e m, input logic [7:0] p);
    logic [7:0] r;
    case (m)
      MODE_SHL:   r = {p[6:0], p[7]};
      MODE_SHR:   r = {p[0], p[7:1]};
      MODE_SPLIT: r = {p[6:4], p[7], p[0], p[3:1]};
      MODE_BLINK: r = ~p;
      default:    r = p;
    endcase
    return r;
  endfunction

  led_tick_gen #(
    .TICK_BASE (TICK_BASE),
    .CNT_W     (CNT_W)
  ) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .speed_sel (speed_sel),
    .pause     (pause),
    .restart   (restart),
    .tick      (tick)
  );

  assign ovr_ready = (mode_q != MODE_OVERRIDE);
  assign accept    = ovr_valid && ovr_ready;
  assign led_n     = led_q;
  assign mode      = mode_q;

  // Next state: override accept beats mode_req, which beats a same-cycle tick.
  always_comb begin
    mode_d  = mode_q;
    saved_d = saved_q;
    led_d   = led_q;
    hold_d  = hold_q;
    restart = 1'b0;
    if (accept) begin
      saved_d = mode_req ? next_mode(mode_q) : mode_q;
      mode_d  = MODE_OVERRIDE;
      led_d   = ovr_data;
      hold_d  = '0;
      restart = 1'b1;
    end else if (mode_q == MODE_OVERRIDE) begin
      // Key presses during an override only queue up the mode to return to.
      if (mode_req) begin
        saved_d = next_mode(saved_q);
      end
      if (tick) begin
        if (hold_q == HOLD_LAST) begin
          mode_d  = saved_d;
          led_d   = mode_seed(saved_d);
          hold_d  = '0;
          restart = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end else if (mode_req) begin
      mode_d  = next_mode(mode_q);
      led_d   = mode_seed(mode_d);
      restart = 1'b1;
    end else if (tick) begin
      led_d = step_pattern(mode_q, led_q);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      saved_q <= MODE_OFF;
      led_q   <= LED_ALL_OFF;
      hold_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      saved_q <= saved_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench: directed test plan plus random stimulus against a behavioural model.
module tb_led_pattern_ctrl;

  localparam int TB = 8;
  localparam int OT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_req = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic       pause = 1'b0;
  logic       ovr_valid = 1'b0;
  logic [7:0] ovr_data = 8'h00;
  logic       ovr_ready;
  logic [7:0] led_n;
  logic [2:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_mode, m_saved, m_led, m_cnt, m_hold, m_spd;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .TICK_BASE (TB),
    .OVR_TICKS (OT),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_req  (mode_req),
    .speed_sel (speed_sel),
    .pause     (pause),
    .ovr_valid (ovr_valid),
    .ovr_data  (ovr_data),
    .ovr_ready (ovr_ready),
    .led_n     (led_n),
    .mode      (mode),
    .tick      (tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int seed_of(input int m);
    case (m)
      1: return 8'hFE;
      2: return 8'h7F;
      3: return 8'hE7;
      4: return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int pat_of(input int m, input int x);
    int lo, hi;
    case (m)
      1: return ((x * 2) % 256) + (x / 128);
      2: return (x / 2) + (x % 2) * 128;
      3: begin
        lo = x % 16;
        hi = x / 16;
        lo = (lo / 2) + (lo % 2) * 8;
        hi = ((hi * 2) % 16) + (hi / 8);
        return hi * 16 + lo;
      end
      4: return 255 - x;
      default: return x;
    endcase
  endfunction

  function automatic int adv(input int m);
    return (m + 1) % 5;
  endfunction

  function automatic bit m_tick();
    return !pause && (int'(speed_sel) == m_spd) && (m_cnt == (TB >> speed_sel) - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_saved = 0; m_led = 8'hFF; m_cnt = 0; m_hold = 0; m_spd = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit t, acc, rs;
    int per;
    t   = m_tick();
    acc = ovr_valid && (m_mode != 5);
    rs  = 0;
    per = TB >> speed_sel;
    if (acc) begin
      m_saved = mode_req ? adv(m_mode) : m_mode;
      m_mode  = 5;
      m_led   = int'(ovr_data);
      m_hold  = 0;
      rs      = 1;
    end else if (m_mode == 5) begin
      if (mode_req) m_saved = adv(m_saved);
      if (t) begin
        if (m_hold == OT - 1) begin
          m_mode = m_saved;
          m_led  = seed_of(m_mode);
          m_hold = 0;
          rs     = 1;
        end else begin
          m_hold++;
        end
      end
    end else if (mode_req) begin
      m_mode = adv(m_mode);
      m_led  = seed_of(m_mode);
      rs     = 1;
    end else if (t) begin
      m_led = pat_of(m_mode, m_led);
    end
    if (rs || int'(speed_sel) != m_spd) m_cnt = 0;
    else if (!pause) m_cnt = (m_cnt == per - 1) ? 0 : m_cnt + 1;
    m_spd = int'(speed_sel);
  endtask

  // Compare all outputs against the model, then clock once.
  task automatic step_cycle();
    #2;
    check_eq("led_n", 32'(led_n), 32'(m_led));
    check_eq("mode", 32'(mode), 32'(m_mode));
    check_eq("ovr_ready", 32'(ovr_ready), 32'(m_mode != 5));
    check_eq("tick", 32'(tick), 32'(m_tick()));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic pulse_mode();
    mode_req = 1'b1;
    step_cycle();
    mode_req = 1'b0;
  endtask

  logic [7:0] split_seq [4];

  initial begin
    split_seq[0] = 8'hDB; split_seq[1] = 8'hBD; split_seq[2] = 8'h7E; split_seq[3] = 8'hE7;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: reset in the middle of a run
    pulse_mode();
    steps(5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_led", 32'(led_n), 32'hFF);
    check_eq("rst_mode", 32'(mode), 32'd0);
    check_eq("rst_ready", 32'(ovr_ready), 32'd1);
    check_eq("rst_tick", 32'(tick), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #2;
      check_eq("no_tick_after_rst", 32'(tick), 32'd0);
      #(-0);
      model_step();
      @(posedge clk);
      #1;
    end
    steps(10);
    check_eq("off_led", 32'(led_n), 32'hFF);

    // 2: SPLIT sequence
    pulse_mode(); pulse_mode(); pulse_mode();
    check_eq("split_seed", 32'(led_n), 32'hE7);
    for (int k = 0; k < 4; k++) begin
      steps(8);
      check_eq("split_step", 32'(led_n), 32'(split_seq[k]));
    end

    // 3: SHIFT_L with a speed change mid-count
    pulse_mode(); pulse_mode(); pulse_mode();
    check_eq("shl_seed", 32'(led_n), 32'hFE);
    steps(3);
    speed_sel = 2'd2;
    steps(1);
    steps(2);
    check_eq("shl_fast1", 32'(led_n), 32'hFD);
    steps(2);
    check_eq("shl_fast2", 32'(led_n), 32'hFB);

    // 4: override from SHIFT_R, second request waits for return
    speed_sel = 2'd0;
    pulse_mode();
    check_eq("shr_seed", 32'(led_n), 32'h7F);
    steps(3);
    ovr_valid = 1'b1;
    ovr_data  = 8'hA5;
    step_cycle();
    ovr_data = 8'h3C;
    check_eq("ovr_ready_low", 32'(ovr_ready), 32'd0);
    check_eq("ovr_led", 32'(led_n), 32'hA5);
    steps(23);
    check_eq("ovr_hold_led", 32'(led_n), 32'hA5);
    steps(1);
    check_eq("ovr_ret_mode", 32'(mode), 32'd2);
    check_eq("ovr_ret_led", 32'(led_n), 32'h7F);
    step_cycle();
    ovr_valid = 1'b0;
    check_eq("ovr2_led", 32'(led_n), 32'h3C);
    steps(24);
    check_eq("ovr2_ret_mode", 32'(mode), 32'd2);

    // 5: mode_req and accept together from BLINK
    pulse_mode(); pulse_mode();
    check_eq("blink_seed", 32'(led_n), 32'h00);
    mode_req  = 1'b1;
    ovr_valid = 1'b1;
    ovr_data  = 8'h5A;
    step_cycle();
    mode_req  = 1'b0;
    ovr_valid = 1'b0;
    check_eq("both_mode", 32'(mode), 32'd5);
    check_eq("both_led", 32'(led_n), 32'h5A);
    steps(24);
    check_eq("both_ret_mode", 32'(mode), 32'd0);
    check_eq("both_ret_led", 32'(led_n), 32'hFF);

    // 6: pause in SPLIT
    pulse_mode(); pulse_mode(); pulse_mode();
    steps(3);
    pause = 1'b1;
    steps(20);
    check_eq("pause_led", 32'(led_n), 32'hE7);
    pause = 1'b0;
    steps(4);
    check_eq("resume_led_pre", 32'(led_n), 32'hE7);
    steps(1);
    check_eq("resume_led_step", 32'(led_n), 32'hDB);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      mode_req  = ($urandom_range(0, 15) == 0);
      ovr_valid = ($urandom_range(0, 19) == 0);
      ovr_data  = 8'($urandom);
      if ($urandom_range(0, 63) == 0) speed_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) pause = ~pause;
      step_cycle();
    end
    mode_req  = 1'b0;
    ovr_valid = 1'b0;
    pause     = 1'b0;
    steps(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
